// File: rtl/frame_sequencer.sv
// Frame sequencer for the 3x3 edge-detect engine: walks the frame column by column,
// fetches each window column over the read port, triggers the filter, then writes back.
module frame_sequencer #(
  parameter int BUSWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUSWIDTH-1:0] width,
  input  logic [BUSWIDTH-1:0] height,
  input  logic [BUSWIDTH-1:0] read_base,
  input  logic [BUSWIDTH-1:0] write_base,
  input  logic                filter_type,
  output logic                rd_req,
  output logic [BUSWIDTH-1:0] rd_addr,
  input  logic                rd_ack,
  output logic                win_load,
  output logic [1:0]          win_row,
  output logic                comp_start,
  input  logic                comp_done,
  output logic                wr_req,
  output logic [BUSWIDTH-1:0] wr_addr,
  input  logic                wr_ack,
  output logic                filter_sel,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_COMPUTE,
    S_WRITE,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [BUSWIDTH-1:0] r_width;
  logic [BUSWIDTH-1:0] r_height;
  logic [BUSWIDTH-1:0] r_read_base;
  logic [BUSWIDTH-1:0] r_write_base;
  logic [BUSWIDTH-1:0] r_col;
  logic [BUSWIDTH-1:0] r_row;
  logic [BUSWIDTH-1:0] r_top_ptr;
  logic [BUSWIDTH-1:0] r_wr_row_ptr;
  logic [BUSWIDTH-1:0] r_rd_addr;
  logic [BUSWIDTH-1:0] r_wr_addr;
  logic [1:0]          r_k;
  logic                r_filter;
  logic                r_rd_req;
  logic                r_wr_req;
  logic                r_comp_start;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic w_cfg_bad;
  logic w_last_col;
  logic w_last_row;
  logic w_prefill;

  assign w_cfg_bad  = (r_width < BUSWIDTH'(3)) || (r_height < BUSWIDTH'(3));
  assign w_last_col = (r_col == r_width - BUSWIDTH'(1));
  assign w_last_row = (r_row == r_height - BUSWIDTH'(2));
  // The first two columns of each row only fill the window; no pixel is computed yet.
  assign w_prefill  = (r_col < BUSWIDTH'(2));

  assign rd_req     = r_rd_req;
  assign rd_addr    = r_rd_addr;
  assign win_load   = r_rd_req & rd_ack;
  assign win_row    = r_k;
  assign comp_start = r_comp_start;
  assign wr_req     = r_wr_req;
  assign wr_addr    = r_wr_addr;
  assign filter_sel = r_filter;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_read_base  <= '0;
      r_write_base <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_top_ptr    <= '0;
      r_wr_row_ptr <= '0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_k          <= '0;
      r_filter     <= 1'b0;
      r_rd_req     <= 1'b0;
      r_wr_req     <= 1'b0;
      r_comp_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_comp_start <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_width      <= width;
            r_height     <= height;
            r_read_base  <= read_base;
            r_write_base <= write_base;
            r_filter     <= filter_type;
            r_state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_bad) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_col        <= '0;
            r_row        <= BUSWIDTH'(1);
            r_top_ptr    <= r_read_base;
            r_wr_row_ptr <= r_write_base + r_width;
            r_k          <= '0;
            r_busy       <= 1'b1;
            r_rd_req     <= 1'b1;
            r_rd_addr    <= r_read_base;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_ack) begin
            if (r_k == 2'd2) begin
              r_k      <= '0;
              r_rd_req <= 1'b0;
              if (w_prefill) begin
                r_state <= S_ADVANCE;
              end else begin
                r_comp_start <= 1'b1;
                r_state      <= S_COMPUTE;
              end
            end else begin
              // Step one image row down the current column.
              r_k       <= r_k + 2'd1;
              r_rd_addr <= r_rd_addr + r_width;
            end
          end
        end
        S_COMPUTE: begin
          if (comp_done) begin
            r_wr_req  <= 1'b1;
            r_wr_addr <= r_wr_row_ptr + r_col - BUSWIDTH'(1);
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            r_wr_req <= 1'b0;
            r_state  <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (!w_last_col) begin
            r_col     <= r_col + BUSWIDTH'(1);
            r_rd_addr <= r_top_ptr + r_col + BUSWIDTH'(1);
            r_rd_req  <= 1'b1;
            r_state   <= S_FETCH;
          end else if (w_last_row) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_col        <= '0;
            r_row        <= r_row + BUSWIDTH'(1);
            r_top_ptr    <= r_top_ptr + r_width;
            r_wr_row_ptr <= r_wr_row_ptr + r_width;
            r_rd_addr    <= r_top_ptr + r_width;
            r_rd_req     <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
